// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle RV32I core: drives per-state datapath
// enables, shares one memory port with a ready handshake, counts retirements.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             Zero,
  input  logic             Sign,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             halted,
  output logic             retired,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic             retired_q, retired_d;
  logic [CNT_W-1:0] cnt_q;

  logic       pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic       alu_f3_ok, br_f3_ok, taken;

  // Only add/slt/or/and and beq/bne/blt are implemented; the rest trap.
  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100);

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Sign;
      default: taken = 1'b0;
    endcase
  end

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic use_sub);
    case (f3)
      3'b000:  return use_sub ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    retired_d   = 1'b0;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target is precomputed here and parked in ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = alu_f3_ok ? S_EXECUTER : S_TRAP;
          OP_ITYPE:          state_d = alu_f3_ok ? S_EXECUTEI : S_TRAP;
          OP_BRANCH:         state_d = br_f3_ok  ? S_BRANCH   : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
        retired_d  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d   = S_FETCH;
          retired_d = 1'b1;
        end
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = alu_decode(funct3, funct7);
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_decode(funct3, 1'b0);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retired_d = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = taken;
        state_d     = S_FETCH;
        retired_d   = 1'b1;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_FETCH;
      retired_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      if (retired_d) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Enables are gated by reset directly so an aborted access drops at once.
  assign PCWrite    = pc_write  & ~arst;
  assign IRWrite    = ir_write  & ~arst;
  assign MemWrite   = mem_write & ~arst;
  assign RegWrite   = reg_write & ~arst;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ALUControl = alu_control;
  assign halted     = (state_q == S_TRAP);
  assign retired    = retired_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, memory wait
// states, traps, reset abort and counter wrap on a narrow second instance.
module tb_multicycle_control;

  logic        clk, arst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7, Zero, Sign, mem_ready;
  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic        halted, retired;
  logic [31:0] instr_cnt;

  logic        n4_pcw, n4_adr, n4_irw, n4_mw, n4_rw;
  logic [1:0]  n4_res, n4_a, n4_b, n4_imm;
  logic [2:0]  n4_alu;
  logic        n4_halted, n4_retired;
  logic [3:0]  n4_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  int         lat, n_adr, n_mw, mw_run, n_rw, n_rw_rd, n_pcw_br, rw_at;
  logic [2:0] alu_ex;
  logic       timeout;

  multicycle_control dut (
    .clk(clk), .arst(arst), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Sign(Sign), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .halted(halted), .retired(retired),
    .instr_cnt(instr_cnt)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .arst(arst), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Sign(Sign), .mem_ready(mem_ready),
    .PCWrite(n4_pcw), .AdrSrc(n4_adr), .IRWrite(n4_irw), .MemWrite(n4_mw),
    .RegWrite(n4_rw), .ResultSrc(n4_res), .ALUSrcA(n4_a), .ALUSrcB(n4_b),
    .ImmSrc(n4_imm), .ALUControl(n4_alu), .halted(n4_halted), .retired(n4_retired),
    .instr_cnt(n4_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] ins);
    op     = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[30];
  endtask

  // Runs one instruction from FETCH until the retire pulse, stalling the data
  // access for 'waits' cycles and recording what the control outputs did.
  task automatic run_instr(input logic [31:0] ins, input int waits);
    int left;
    int run;
    left = waits;
    run  = 0;
    set_instr(ins);
    lat = 0; n_adr = 0; n_mw = 0; mw_run = 0; n_rw = 0; n_rw_rd = 0;
    n_pcw_br = 0; rw_at = 0; alu_ex = 3'b111; timeout = 1'b0;
    forever begin
      lat++;
      if (AdrSrc && left > 0) begin
        mem_ready = 1'b0;
        left--;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (AdrSrc) n_adr++;
      if (MemWrite) begin
        n_mw++;
        run++;
        if (run > mw_run) mw_run = run;
      end else begin
        run = 0;
      end
      if (RegWrite) begin
        n_rw++;
        rw_at = lat;
        if (ResultSrc == 2'b01) n_rw_rd++;
      end
      if (PCWrite && !IRWrite) n_pcw_br++;
      if (ALUSrcA == 2'b10) alu_ex = ALUControl;
      tick();
      if (retired) break;
      if (lat >= 40) begin
        timeout = 1'b1;
        break;
      end
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] en_or;
    logic       hold_ok;
    logic [31:0] addi;
    addi = 32'h00500093;

    arst = 1'b1; mem_ready = 1'b1; Zero = 1'b0; Sign = 1'b0;
    set_instr(addi);
    repeat (3) tick();
    check("rst_cnt", instr_cnt, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", {31'd0, retired}, 32'd0);
    check("rst_enables", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);

    arst = 1'b0;
    #1;
    check("fetch_outputs",
          {20'd0, PCWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl},
          {20'd0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000});

    // Two back-to-back addi: RegWrite in cycles 4 and 8
    run_instr(addi, 0);
    check("addi1_lat", lat, 4);
    check("addi1_rw_at", rw_at, 4);
    check("addi1_n_rw", n_rw, 1);
    run_instr(addi, 0);
    check("addi2_lat", lat, 4);
    check("addi2_rw_at", rw_at, 4);
    check("addi_cnt", instr_cnt, 32'd2);
    check("addi_retired", {31'd0, retired}, 32'd1);

    // lw with 3 data wait cycles
    run_instr(32'h0000A103, 3);
    check("lw_timeout", {31'd0, timeout}, 32'd0);
    check("lw_lat", lat, 8);
    check("lw_adrsrc_cycles", n_adr, 4);
    check("lw_rw_readdata", n_rw_rd, 1);
    check("lw_rw_at", rw_at, 8);
    check("lw_cnt", instr_cnt, 32'd3);

    // sw with 2 wait cycles
    set_instr(32'h0020A023);
    #1;
    check("sw_immsrc", {30'd0, ImmSrc}, 32'd1);
    run_instr(32'h0020A023, 2);
    check("sw_lat", lat, 6);
    check("sw_mw_cycles", n_mw, 3);
    check("sw_mw_run", mw_run, 3);
    check("sw_no_rw", n_rw, 0);
    check("sw_cnt", instr_cnt, 32'd4);

    // Branches: beq taken / not taken, blt taken, bne taken
    set_instr(32'h00208463);
    #1;
    check("beq_immsrc", {30'd0, ImmSrc}, 32'd2);
    Zero = 1'b1;
    run_instr(32'h00208463, 0);
    check("beq_t_lat", lat, 3);
    check("beq_t_pcw", n_pcw_br, 1);
    check("beq_alu_sub", {29'd0, alu_ex}, 32'd1);
    Zero = 1'b0;
    run_instr(32'h00208463, 0);
    check("beq_nt_pcw", n_pcw_br, 0);
    Sign = 1'b1;
    run_instr(32'h0020C463, 0);
    check("blt_t_pcw", n_pcw_br, 1);
    Sign = 1'b0;
    run_instr(32'h00209463, 0);
    check("bne_t_pcw", n_pcw_br, 1);
    check("branch_cnt", instr_cnt, 32'd8);

    // jal: PCWrite in JAL, link write in ALUWB, single retire
    set_instr(32'h008000EF);
    #1;
    check("jal_immsrc", {30'd0, ImmSrc}, 32'd3);
    run_instr(32'h008000EF, 0);
    check("jal_lat", lat, 4);
    check("jal_pcw", n_pcw_br, 1);
    check("jal_rw", n_rw, 1);
    check("jal_cnt", instr_cnt, 32'd9);

    // R-type ALU decode and I-type funct7 ignore
    run_instr(32'h40208033, 0);
    check("sub_alu", {29'd0, alu_ex}, 32'd1);
    check("sub_lat", lat, 4);
    run_instr(32'h0020E033, 0);
    check("or_alu", {29'd0, alu_ex}, 32'd3);
    run_instr(32'h0020A033, 0);
    check("slt_alu", {29'd0, alu_ex}, 32'd5);
    run_instr(32'h0020F033, 0);
    check("and_alu", {29'd0, alu_ex}, 32'd2);
    run_instr(32'h40008093, 0);
    check("addi_f7_alu", {29'd0, alu_ex}, 32'd0);
    check("alu_cnt", instr_cnt, 32'd14);

    // Unsupported R funct3 traps; sticky for 20 cycles; arst clears
    set_instr(32'h0020B033);
    tick();
    tick();
    check("trap_halted", {31'd0, halted}, 32'd1);
    en_or = 4'd0;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      en_or |= {PCWrite, IRWrite, MemWrite, RegWrite};
      hold_ok &= halted;
      tick();
    end
    check("trap_no_enables", {28'd0, en_or}, 32'd0);
    check("trap_sticky", {31'd0, hold_ok}, 32'd1);
    check("trap_cnt", instr_cnt, 32'd14);
    arst = 1'b1;
    #1;
    check("trap_clr_halted", {31'd0, halted}, 32'd0);
    check("trap_clr_cnt", instr_cnt, 32'd0);
    tick();
    arst = 1'b0;

    // Unknown opcode (lui) also traps
    set_instr(32'h000000B7);
    tick();
    tick();
    check("lui_trap", {31'd0, halted}, 32'd1);
    arst = 1'b1;
    tick();
    arst = 1'b0;

    // 17 addi: 32-bit counter reads 17, 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) run_instr(addi, 0);
    #1;
    check("wrap_cnt32", instr_cnt, 32'd17);
    check("wrap_cnt4", {28'd0, n4_cnt}, 32'd1);
    check("wrap_n4_outputs",
          {9'd0, n4_pcw, n4_adr, n4_irw, n4_mw, n4_rw, n4_res, n4_a, n4_b, n4_imm,
           n4_alu, n4_halted, n4_retired, n4_cnt},
          {9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00,
           3'b000, 1'b0, 1'b1, 4'd1});

    // arst in MEMWRITE: strobe drops immediately, FSM back in FETCH
    set_instr(32'h0020A023);
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("abort_mw_before", {31'd0, MemWrite}, 32'd1);
    #2;
    arst = 1'b1;
    #1;
    check("abort_mw_dropped", {31'd0, MemWrite}, 32'd0);
    mem_ready = 1'b1;
    #1;
    check("abort_fetch_state", {25'd0, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB},
          {25'd0, 1'b0, 2'b10, 2'b00, 2'b10});
    check("abort_gated", {30'd0, PCWrite, IRWrite}, 32'd0);
    tick();
    arst = 1'b0;
    #1;
    check("abort_irwrite", {31'd0, IRWrite}, 32'd1);
    check("abort_cnt", instr_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
